// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default timing for the PWM pad source selector.
// The defaults assume a 50 MHz clock and standard 0.8-2.2 ms RC pulses.
package pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_SYS      = 3'd0,
    S_TO_RF    = 3'd1,
    S_RF       = 3'd2,
    S_TO_SYS   = 3'd3,
    S_FAILSAFE = 3'd4
  } pwm_src_state_t;

  localparam int DEF_PW_MIN      = 40_000;
  localparam int DEF_PW_MAX      = 110_000;
  localparam int DEF_RF_TIMEOUT  = 2_500_000;
  localparam int DEF_SW_TIMEOUT  = 1_250_000;
  localparam int DEF_RECOVER_CNT = 8;

  function automatic logic drives_rf(input pwm_src_state_t s);
    return (s == S_RF) || (s == S_TO_SYS);
  endfunction

endpackage

// File: rtl/pwm_src_ctrl_if.sv
// Register-bank/pad side signals of the PWM source selector.
// The master is the register bank, and the selector is the slave.
interface pwm_src_ctrl_if;

  logic [1:0] pwm_rf_i;
  logic [1:0] pwm_sys_i;
  logic       sel_rf_i;
  logic       failsafe_en_i;
  logic [1:0] pwm_pad_o;
  logic       src_rf_o;
  logic       rf_ok_o;
  logic       failsafe_o;
  logic [2:0] state_o;

  modport master (
    output pwm_rf_i, pwm_sys_i, sel_rf_i, failsafe_en_i,
    input  pwm_pad_o, src_rf_o, rf_ok_o, failsafe_o, state_o
  );

  modport slave (
    input  pwm_rf_i, pwm_sys_i, sel_rf_i, failsafe_en_i,
    output pwm_pad_o, src_rf_o, rf_ok_o, failsafe_o, state_o
  );

endinterface

// File: rtl/pwm_pulse_monitor.sv
// Synchronises the RF pads and judges RF link health from ch0 pulse widths.
// rf_ok asserts after enough consecutive good pulses and drops when the watchdog runs out.
module pwm_pulse_monitor
  import pwm_ctrl_pkg::*;
#(
  parameter int PW_MIN      = DEF_PW_MIN,
  parameter int PW_MAX      = DEF_PW_MAX,
  parameter int RF_TIMEOUT  = DEF_RF_TIMEOUT,
  parameter int RECOVER_CNT = DEF_RECOVER_CNT,
  parameter int CNT_W       = $clog2(RF_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pwm_rf,
  output logic [1:0] rf_sync,
  output logic       rf_ok,
  output logic       pulse_valid
);

  localparam int WID_W = $clog2(PW_MAX + 2);
  localparam int REC_W = $clog2(RECOVER_CNT + 1);
  localparam logic [WID_W-1:0] W_MIN   = WID_W'(PW_MIN);
  localparam logic [WID_W-1:0] W_MAX   = WID_W'(PW_MAX);
  localparam logic [WID_W-1:0] W_SAT   = WID_W'(PW_MAX + 1);
  localparam logic [CNT_W-1:0] WD_LOAD = CNT_W'(RF_TIMEOUT);
  localparam logic [REC_W-1:0] REC_MAX = REC_W'(RECOVER_CNT);

  logic [1:0]       rf_meta;
  logic             ch0_d;
  logic [WID_W-1:0] width;
  logic [CNT_W-1:0] wd;
  logic [REC_W-1:0] rec_cnt;
  logic [REC_W-1:0] rec_next;
  logic             rise;
  logic             fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_meta <= 2'b00;
      rf_sync <= 2'b00;
      ch0_d   <= 1'b0;
    end else begin
      rf_meta <= pwm_rf;
      rf_sync <= rf_meta;
      ch0_d   <= rf_sync[0];
    end
  end

  assign rise = rf_sync[0] & ~ch0_d;
  assign fall = ~rf_sync[0] & ch0_d;

  // width holds the number of high cycles seen so far, saturating just past PW_MAX
  always_ff @(posedge clk) begin
    if (rst) begin
      width <= '0;
    end else if (rise) begin
      width <= WID_W'(1);
    end else if (rf_sync[0] && (width != W_SAT)) begin
      width <= width + 1'b1;
    end
  end

  assign pulse_valid = fall && (width >= W_MIN) && (width <= W_MAX);
  assign rec_next    = (rec_cnt == REC_MAX) ? rec_cnt : rec_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd <= '0;
    end else if (pulse_valid) begin
      wd <= WD_LOAD;
    end else if (wd != '0) begin
      wd <= wd - 1'b1;
    end
  end

  // expiry wins over nothing else: a valid pulse in the same cycle reloads instead
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_cnt <= '0;
      rf_ok   <= 1'b0;
    end else if (pulse_valid) begin
      rec_cnt <= rec_next;
      if (rec_next == REC_MAX) begin
        rf_ok <= 1'b1;
      end
    end else begin
      if (fall) begin
        rec_cnt <= '0;
      end
      if (wd == CNT_W'(1)) begin
        rec_cnt <= '0;
        rf_ok   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_src_ctrl.sv
// Chooses RF or system PWM for the pads, switching only between pulses,
// and falls back to the system source while the RF link is unhealthy.
module pwm_src_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int PW_MIN      = DEF_PW_MIN,
  parameter int PW_MAX      = DEF_PW_MAX,
  parameter int RF_TIMEOUT  = DEF_RF_TIMEOUT,
  parameter int SW_TIMEOUT  = DEF_SW_TIMEOUT,
  parameter int RECOVER_CNT = DEF_RECOVER_CNT,
  parameter int CNT_W       = $clog2(RF_TIMEOUT + 1)
) (
  input logic            clk,
  input logic            rst,
  pwm_src_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] SW_LAST = CNT_W'(SW_TIMEOUT - 1);

  pwm_src_state_t   state;
  pwm_src_state_t   state_next;
  logic [1:0]       rf_sync;
  logic             rf_ok;
  logic             pulse_valid_unused;
  logic [CNT_W-1:0] sw_timer;
  logic             safe;
  logic             sw_expired;
  logic             loss;
  logic             entering;
  logic             mux_rf;
  logic [1:0]       pad;
  logic             src_rf;

  pwm_pulse_monitor #(
    .PW_MIN      (PW_MIN),
    .PW_MAX      (PW_MAX),
    .RF_TIMEOUT  (RF_TIMEOUT),
    .RECOVER_CNT (RECOVER_CNT),
    .CNT_W       (CNT_W)
  ) u_mon (
    .clk         (clk),
    .rst         (rst),
    .pwm_rf      (bus.pwm_rf_i),
    .rf_sync     (rf_sync),
    .rf_ok       (rf_ok),
    .pulse_valid (pulse_valid_unused)
  );

  assign safe       = (rf_sync == 2'b00) && (bus.pwm_sys_i == 2'b00);
  assign sw_expired = (sw_timer == SW_LAST);
  assign loss       = ~rf_ok & bus.failsafe_en_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_SYS;
    end else begin
      state <= state_next;
    end
  end

  // loss never waits for a safe point when leaving RF: the RF line may be stuck high
  always_comb begin
    state_next = state;
    unique case (state)
      S_SYS: begin
        if (bus.sel_rf_i && (rf_ok || !bus.failsafe_en_i)) state_next = S_TO_RF;
      end
      S_TO_RF: begin
        if (safe || sw_expired)    state_next = S_RF;
        else if (loss)             state_next = S_FAILSAFE;
        else if (!bus.sel_rf_i)    state_next = S_SYS;
      end
      S_RF: begin
        if (loss)                  state_next = S_FAILSAFE;
        else if (!bus.sel_rf_i)    state_next = S_TO_SYS;
      end
      S_TO_SYS: begin
        if (loss || safe || sw_expired) state_next = S_SYS;
        else if (bus.sel_rf_i)          state_next = S_RF;
      end
      S_FAILSAFE: begin
        if (!bus.sel_rf_i)                       state_next = S_SYS;
        else if (rf_ok || !bus.failsafe_en_i)    state_next = S_TO_RF;
      end
      default: state_next = S_SYS;
    endcase
  end

  always_comb begin
    mux_rf         = drives_rf(state);
    bus.failsafe_o = (state == S_FAILSAFE);
    bus.state_o    = state;
    bus.rf_ok_o    = rf_ok;
    bus.pwm_pad_o  = pad;
    bus.src_rf_o   = src_rf;
  end

  assign entering = ((state_next == S_TO_RF) && (state != S_TO_RF)) ||
                    ((state_next == S_TO_SYS) && (state != S_TO_SYS));

  always_ff @(posedge clk) begin
    if (rst || entering) begin
      sw_timer <= '0;
    end else if (((state == S_TO_RF) || (state == S_TO_SYS)) && !sw_expired) begin
      sw_timer <= sw_timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pad    <= 2'b00;
      src_rf <= 1'b0;
    end else begin
      pad    <= mux_rf ? rf_sync : bus.pwm_sys_i;
      src_rf <= mux_rf;
    end
  end

endmodule

// File: tb/tb_pwm_src_ctrl.sv
// Self-checking bench for pwm_src_ctrl with short test timings; pad values go
// through a latency-aware scoreboard, state and health flags are checked at fixed cycles.
module tb_pwm_src_ctrl;

  logic clk = 1'b0;
  logic rst;

  pwm_src_ctrl_if bus ();

  pwm_src_ctrl #(
    .PW_MIN      (4),
    .PW_MAX      (10),
    .RF_TIMEOUT  (64),
    .SW_TIMEOUT  (32),
    .RECOVER_CNT (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sys;
    logic [1:0] rf;
    logic [1:0] exp_pad;
    logic [2:0] exp_state;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  vec_t       tbl[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // lat=1 scores the SYS path, lat=3 the RF path, lat=0 drives without scoring
  task automatic applyStimulus(input logic [1:0] sys, input logic [1:0] rf, input int lat);
    logic [1:0] e;
    bus.pwm_sys_i = sys;
    bus.pwm_rf_i  = rf;
    if (lat != 0) exp_q.push_back((lat == 1) ? sys : rf);
    @(posedge clk);
    #1;
    if ((lat != 0) && (exp_q.size() >= lat)) begin
      e = exp_q.pop_front();
      checkOutput("pad", 32'(bus.pwm_pad_o), 32'(e));
    end
  endtask

  task automatic rfPulse(input int width, input int gap, input logic [1:0] sys, input int lat);
    for (int i = 0; i < width; i++) applyStimulus(sys, 2'b01, lat);
    for (int i = 0; i < gap; i++)   applyStimulus(sys, 2'b00, lat);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [1:0] e;

    tbl = '{
      '{2'b00, 2'b00, 2'b00, 3'd0},
      '{2'b01, 2'b10, 2'b01, 3'd0},
      '{2'b11, 2'b01, 2'b11, 3'd0},
      '{2'b10, 2'b01, 2'b10, 3'd0},
      '{2'b00, 2'b11, 2'b00, 3'd0},
      '{2'b01, 2'b00, 2'b01, 3'd0},
      '{2'b10, 2'b10, 2'b10, 3'd0},
      '{2'b11, 2'b00, 2'b11, 3'd0}
    };

    rst               = 1'b1;
    bus.sel_rf_i      = 1'b0;
    bus.failsafe_en_i = 1'b1;
    bus.pwm_sys_i     = 2'b11;
    bus.pwm_rf_i      = 2'b00;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_pad", 32'(bus.pwm_pad_o), 0);
    checkOutput("rst_src_rf", 32'(bus.src_rf_o), 0);
    checkOutput("rst_rf_ok", 32'(bus.rf_ok_o), 0);
    checkOutput("rst_failsafe", 32'(bus.failsafe_o), 0);
    checkOutput("rst_state", 32'(bus.state_o), 0);
    rst = 1'b0;

    // SYS source with RF noise that must never reach the pads
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tbl[i].exp_pad);
      bus.pwm_sys_i = tbl[i].sys;
      bus.pwm_rf_i  = tbl[i].rf;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checkOutput("tbl_pad", 32'(bus.pwm_pad_o), 32'(e));
      checkOutput("tbl_state", 32'(bus.state_o), 32'(tbl[i].exp_state));
      checkOutput("tbl_src_rf", 32'(bus.src_rf_o), 0);
      checkOutput("tbl_rf_ok", 32'(bus.rf_ok_o), 0);
    end

    // three valid RF pulses bring the link up
    rfPulse(6, 4, 2'b00, 1);
    checkOutput("rec1_rf_ok", 32'(bus.rf_ok_o), 0);
    rfPulse(6, 4, 2'b00, 1);
    checkOutput("rec2_rf_ok", 32'(bus.rf_ok_o), 0);
    rfPulse(6, 2, 2'b00, 1);
    checkOutput("rec3_early_rf_ok", 32'(bus.rf_ok_o), 0);
    applyStimulus(2'b00, 2'b00, 1);
    checkOutput("rec3_rf_ok", 32'(bus.rf_ok_o), 1);
    checkOutput("rec3_state", 32'(bus.state_o), 0);

    // request RF while SYS ch0 is mid-pulse: the pulse must finish at full width
    applyStimulus(2'b01, 2'b00, 1);
    applyStimulus(2'b01, 2'b00, 1);
    bus.sel_rf_i = 1'b1;
    applyStimulus(2'b01, 2'b00, 1);
    checkOutput("mid_to_rf", 32'(bus.state_o), 1);
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b00, 1);
    checkOutput("mid_wait", 32'(bus.state_o), 1);
    checkOutput("mid_src_sys", 32'(bus.src_rf_o), 0);
    applyStimulus(2'b00, 2'b00, 1);
    checkOutput("mid_rf", 32'(bus.state_o), 2);
    checkOutput("mid_src_lag", 32'(bus.src_rf_o), 0);
    exp_q.delete();
    applyStimulus(2'b00, 2'b00, 3);
    checkOutput("mid_src_rf", 32'(bus.src_rf_o), 1);

    // one last valid pulse on the RF path, then ch0 sticks high
    for (int i = 0; i < 6; i++) applyStimulus(2'b10, (i % 2 == 0) ? 2'b01 : 2'b11, 3);
    for (int k = 1; k <= 70; k++) begin
      if (k == 69) exp_q.delete();
      applyStimulus(2'b10, (k <= 3) ? 2'b00 : 2'b01, (k <= 68) ? 3 : 1);
      if (k == 66) checkOutput("wd_rf_ok_hold", 32'(bus.rf_ok_o), 1);
      if (k == 67) begin
        checkOutput("wd_rf_ok_lost", 32'(bus.rf_ok_o), 0);
        checkOutput("wd_state_rf", 32'(bus.state_o), 2);
      end
      if (k == 68) begin
        checkOutput("fs_state", 32'(bus.state_o), 4);
        checkOutput("fs_flag", 32'(bus.failsafe_o), 1);
        checkOutput("fs_src_lag", 32'(bus.src_rf_o), 1);
      end
      if (k == 69) checkOutput("fs_src_sys", 32'(bus.src_rf_o), 0);
    end

    // too-short and too-long pulses never count; three good ones recover
    exp_q.delete();
    for (int i = 0; i < 6; i++) applyStimulus(2'b00, 2'b00, 1);
    rfPulse(2, 6, 2'b00, 1);
    checkOutput("short_rf_ok", 32'(bus.rf_ok_o), 0);
    rfPulse(15, 6, 2'b00, 1);
    checkOutput("long_rf_ok", 32'(bus.rf_ok_o), 0);
    checkOutput("long_state", 32'(bus.state_o), 4);
    rfPulse(6, 6, 2'b00, 1);
    rfPulse(6, 6, 2'b00, 1);
    checkOutput("rec_two_rf_ok", 32'(bus.rf_ok_o), 0);
    for (int k = -5; k <= 5; k++) begin
      applyStimulus(2'b00, (k <= 0) ? 2'b01 : 2'b00, 1);
      if (k == 2) checkOutput("rec_not_yet", 32'(bus.rf_ok_o), 0);
      if (k == 3) begin
        checkOutput("rec_rf_ok", 32'(bus.rf_ok_o), 1);
        checkOutput("rec_still_fs", 32'(bus.state_o), 4);
      end
      if (k == 4) checkOutput("rec_to_rf", 32'(bus.state_o), 1);
      if (k == 5) checkOutput("rec_rf", 32'(bus.state_o), 2);
    end

    // both sources held high: switches are forced after the timeout
    bus.failsafe_en_i = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 2'b11, 3);
    bus.sel_rf_i = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      applyStimulus(2'b11, 2'b11, 0);
      checkOutput("force_sys_state", 32'(bus.state_o), (k <= 32) ? 3 : 0);
      checkOutput("force_sys_pad", 32'(bus.pwm_pad_o), 3);
    end
    checkOutput("force_sys_src", 32'(bus.src_rf_o), 0);
    bus.sel_rf_i = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      applyStimulus(2'b11, 2'b11, 0);
      checkOutput("force_rf_state", 32'(bus.state_o), (k <= 32) ? 1 : 2);
    end
    checkOutput("force_rf_src", 32'(bus.src_rf_o), 1);

    // reset while a switch is pending and the pads are high
    bus.sel_rf_i = 1'b0;
    applyStimulus(2'b11, 2'b11, 0);
    checkOutput("pend_state", 32'(bus.state_o), 3);
    rst = 1'b1;
    applyStimulus(2'b11, 2'b11, 0);
    checkOutput("rst2_pad", 32'(bus.pwm_pad_o), 0);
    checkOutput("rst2_state", 32'(bus.state_o), 0);
    checkOutput("rst2_src_rf", 32'(bus.src_rf_o), 0);
    checkOutput("rst2_rf_ok", 32'(bus.rf_ok_o), 0);
    rst = 1'b0;
    exp_q.delete();
    applyStimulus(2'b00, 2'b00, 1);
    applyStimulus(2'b10, 2'b00, 1);
    checkOutput("post_rst_state", 32'(bus.state_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
